// File: rtl/fb_port_arbiter.sv
// Framebuffer single-port RAM arbiter.
// The LCD line-fetch path gets sequential burst reads and has priority over
// the CPU. A CPU request that keeps losing is guaranteed one slot once it has
// been denied CPU_MAX_WAIT cycles in a row.
module fb_port_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 16,
  parameter int LEN_W        = 10,
  parameter int MAX_BURST    = 800,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              disp_start_i,
  input  logic [ADDR_W-1:0] disp_base_i,
  input  logic [LEN_W-1:0]  disp_len_i,
  output logic              disp_busy_o,
  output logic              disp_rvalid_o,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_done_o,
  output logic              disp_err_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              disp_rv_q;   // owner tag: display read in flight
  logic              cpu_rv_q;    // owner tag: CPU read in flight
  logic              done_q;      // in-flight display read is the last word
  logic              err_q;

  logic in_burst, busy, len_ok, start_ok, force_cpu, gnt, disp_iss;

  // Slot decision for this cycle: display wins in BURST unless the CPU is starved
  always_comb begin
    in_burst  = (state_q == S_BURST);
    // Busy covers the trailing rvalid of the last word, so a new start
    // cannot land before disp_done has been seen.
    busy      = in_burst | done_q;
    len_ok    = (disp_len_i != '0) && (disp_len_i <= LEN_MAX);
    start_ok  = disp_start_i && !busy && len_ok;
    force_cpu = in_burst && cpu_req_i && (wait_q == WAIT_MAX);
    gnt       = cpu_req_i && (!in_burst || force_cpu);
    disp_iss  = in_burst && !force_cpu;
  end

  // Burst sequencing and starvation counter next state
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wait_d  = wait_q;
    if (disp_iss) begin
      addr_d = addr_q + 1'b1;  // wraps at all-ones
      rem_d  = rem_q - 1'b1;
      if (rem_q == LEN_ONE) state_d = S_IDLE;
    end
    // start_ok implies not busy, so it never collides with an issue above
    if (start_ok) begin
      state_d = S_BURST;
      addr_d  = disp_base_i;
      rem_d   = disp_len_i;
    end
    if (!cpu_req_i || gnt)     wait_d = '0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
  end

  // State registers; reset drops any in-flight read and pending done
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      wait_q    <= '0;
      disp_rv_q <= 1'b0;
      cpu_rv_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      disp_rv_q <= disp_iss;
      cpu_rv_q  <= gnt && !cpu_we_i;
      done_q    <= disp_iss && (rem_q == LEN_ONE);
      err_q     <= disp_start_i && !start_ok;
    end
  end

  // RAM-side outputs, combinational and forced to 0 during reset
  always_comb begin
    cpu_gnt_o   = rst_n_i & gnt;
    mem_en_o    = rst_n_i & (gnt | disp_iss);
    mem_we_o    = rst_n_i & gnt & cpu_we_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rst_n_i && gnt)           mem_addr_o = cpu_addr_i;
    else if (rst_n_i && disp_iss) mem_addr_o = addr_q;
    if (rst_n_i && gnt && cpu_we_i) mem_wdata_o = cpu_wdata_i;
  end

  // Read return routing by the registered owner tags
  always_comb begin
    disp_busy_o   = busy;
    disp_rvalid_o = disp_rv_q;
    disp_rdata_o  = disp_rv_q ? mem_rdata_i : '0;
    disp_done_o   = done_q;
    disp_err_o    = err_q;
    cpu_rvalid_o  = cpu_rv_q;
    cpu_rdata_o   = cpu_rv_q ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: RAM model, per-cycle reference model of the
// slot/burst rules, directed scenarios and a randomized phase.
module tb_fb_port_arbiter;
  localparam int AW = 19, DW = 16, LW = 10, MAXB = 800, MAXW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_start;
  logic [AW-1:0] disp_base;
  logic [LW-1:0] disp_len;
  logic          disp_busy, disp_rvalid, disp_done, disp_err;
  logic [DW-1:0] disp_rdata;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_BURST(MAXB),
                    .CPU_MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .disp_start_i(disp_start), .disp_base_i(disp_base), .disp_len_i(disp_len),
    .disp_busy_o(disp_busy), .disp_rvalid_o(disp_rvalid), .disp_rdata_o(disp_rdata),
    .disp_done_o(disp_done), .disp_err_o(disp_err),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
    .cpu_rdata_o(cpu_rdata), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata));

  // RAM model: one access per cycle, read data one cycle later
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  function automatic logic [DW-1:0] initv(int a);
    return 16'(a) ^ 16'((a >> 16) << 13);
  endfunction

  int n_chk = 0, n_pass = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  int            m_rem = 0, m_wait = 0;
  logic [AW-1:0] m_addr = '0;
  bit            p_dv = 0, p_last = 0, p_cv = 0, p_err = 0, rst_prev = 0;
  logic [DW-1:0] p_dd = '0, p_cd = '0;
  // Observations of the last step, plus running event counters
  bit            o_gnt, o_busy, o_done;
  logic [DW-1:0] o_crd;
  bit            o_crv;
  int            n_drv = 0, n_busy = 0, n_err = 0, n_done = 0;

  // One clock cycle: inputs are already driven; check, advance the model, clock
  task automatic step();
    bit e_gnt, e_iss, acc, busy_e;
    #1;
    o_gnt = cpu_gnt; o_busy = disp_busy; o_done = disp_done;
    o_crv = cpu_rvalid; o_crd = cpu_rdata;
    if (disp_rvalid) n_drv++;
    if (disp_busy)   n_busy++;
    if (disp_err)    n_err++;
    if (disp_done)   n_done++;
    if (!rst_n) begin
      chk("rst_gnt", cpu_gnt, 0);     chk("rst_en", mem_en, 0);
      chk("rst_we", mem_we, 0);       chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      if (rst_prev) begin
        chk("rst_busy", disp_busy, 0);  chk("rst_drv", disp_rvalid, 0);
        chk("rst_drd", disp_rdata, 0);  chk("rst_done", disp_done, 0);
        chk("rst_err", disp_err, 0);    chk("rst_crv", cpu_rvalid, 0);
        chk("rst_crd", cpu_rdata, 0);
      end
      m_rem = 0; m_wait = 0; p_dv = 0; p_last = 0; p_cv = 0; p_err = 0;
      rst_prev = 1;
    end else begin
      busy_e = (m_rem > 0) || p_last;
      chk("busy", disp_busy, busy_e);
      chk("d_rv", disp_rvalid, p_dv);
      if (p_dv) chk("d_data", disp_rdata, p_dd);
      chk("done", disp_done, p_last);
      chk("err", disp_err, p_err);
      chk("c_rv", cpu_rvalid, p_cv);
      if (p_cv) chk("c_data", cpu_rdata, p_cd);
      e_gnt = cpu_req && (m_rem == 0 || m_wait == MAXW);
      e_iss = (m_rem > 0) && !e_gnt;
      chk("gnt", cpu_gnt, e_gnt);
      chk("mem_en", mem_en, e_gnt || e_iss);
      if (e_gnt) begin
        chk("c_addr", mem_addr, cpu_addr);
        chk("c_we", mem_we, cpu_we);
        if (cpu_we) chk("c_wdata", mem_wdata, cpu_wdata);
      end
      if (e_iss) begin
        chk("d_addr", mem_addr, m_addr);
        chk("d_we", mem_we, 0);
      end
      p_dv = e_iss; p_dd = ref_mem[m_addr]; p_last = e_iss && (m_rem == 1);
      p_cv = e_gnt && !cpu_we; p_cd = ref_mem[cpu_addr];
      if (e_gnt && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      if (!cpu_req || e_gnt) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
      acc   = disp_start && !busy_e && disp_len >= 1 && disp_len <= MAXB;
      p_err = disp_start && !acc;
      if (e_iss) begin m_addr = m_addr + 1'b1; m_rem--; end
      if (acc) begin m_rem = int'(disp_len); m_addr = disp_base; end
      rst_prev = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(logic [AW-1:0] base, logic [LW-1:0] len);
    disp_start = 1; disp_base = base; disp_len = len;
    step();
    disp_start = 0;
  endtask

  task automatic run_to_done(string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      step();
      if (o_done) break;
    end
    if (i == 3000) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic clr_cnt();
    n_drv = 0; n_busy = 0; n_err = 0; n_done = 0;
  endtask

  initial begin
    int denied, r;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = initv(i); ref_mem[i] = initv(i);
    end
    mem_rdata = '0;
    rst_n = 0; disp_start = 0; disp_base = '0; disp_len = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    @(negedge clk);
    repeat (3) step();
    rst_n = 1;
    step();

    // 1: idle CPU write then read back
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h00100; cpu_wdata = 16'hF800;
    step();
    chk("t1_wgnt", o_gnt, 1);
    cpu_we = 0;
    step();
    chk("t1_rgnt", o_gnt, 1);
    cpu_req = 0;
    step();
    chk("t1_rvalid", o_crv, 1);
    chk("t1_rdata", o_crd, 16'hF800);

    // 2: full line, no CPU traffic
    start(19'h0, 10'd800);
    clr_cnt();
    run_to_done("t2");
    chk("t2_words", n_drv, 800);
    chk("t2_busy", n_busy, 801);
    step();
    chk("t2_idle", o_busy, 0);

    // 3: starvation slot during a 20-word burst
    start(19'h01000, 10'd20);
    clr_cnt();
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'h20010; cpu_wdata = 16'h1234;
    denied = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_gnt) break;
      denied++;
    end
    chk("t3_denied", denied, 8);
    cpu_req = 0;
    run_to_done("t3");
    chk("t3_words", n_drv, 20);
    chk("t3_busy", n_busy, 22);

    // 4: address wrap at all-ones
    start(19'h7FFFE, 10'd4);
    clr_cnt();
    run_to_done("t4");
    chk("t4_words", n_drv, 4);

    // 5: rejected starts
    start(19'h03000, 10'd10);
    clr_cnt();
    step(); step();
    start(19'h0, 10'd5);
    run_to_done("t5");
    chk("t5_words", n_drv, 10);
    chk("t5_err_busy", n_err, 1);
    step();
    start(19'h0, 10'd0);
    step();
    start(19'h0, 10'd801);
    step();
    chk("t5_err_len", n_err, 3);
    chk("t5_nobusy", o_busy, 0);

    // 6: reset mid-burst, then a fresh burst
    start(19'h05000, 10'd30);
    clr_cnt();
    for (int i = 0; i < 100 && n_drv < 10; i++) step();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    repeat (5) step();
    chk("t6_nodone", n_done, 0);
    chk("t6_idle", o_busy, 0);
    start(19'h06000, 10'd5);
    clr_cnt();
    run_to_done("t6");
    chk("t6_words", n_drv, 5);

    // Randomized traffic
    for (int c = 0; c < 5000; c++) begin
      if (cpu_req && o_gnt) cpu_req = 0;
      else if (cpu_req && $urandom_range(0, 31) == 0) cpu_req = 0;
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req   = 1;
        cpu_we    = 1'($urandom);
        cpu_addr  = AW'(32'h20000 + $urandom_range(0, 63));
        cpu_wdata = DW'($urandom);
      end
      disp_start = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 9);
      disp_len  = (r == 0) ? 10'd0 : (r == 1) ? 10'd801 : LW'($urandom_range(1, 40));
      disp_base = ($urandom_range(0, 3) == 0) ? AW'(32'h7FFE0 + $urandom_range(0, 31))
                                              : AW'($urandom_range(0, 32'h1FF00));
      step();
    end
    disp_start = 0; cpu_req = 0;
    repeat (60) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
